// File: rtl/cc_reorder_merge_unit.sv
// In-order merge of buffered cache-hit lines and pass-through memory-miss bursts onto the INCT R channel.
// A hit/miss flag FIFO preserves request order; hit lines are serialised beat by beat from a line FIFO.
module cc_reorder_merge_unit #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned BEATS        = 8,
  parameter int unsigned FLAG_DEPTH   = 4,
  parameter int unsigned HIT_DEPTH    = 2,
  parameter int unsigned AFULL_MARGIN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flag_wren_i,
  input  logic                    flag_wdata_i,
  output logic                    flag_afull_o,
  input  logic                    hit_wren_i,
  input  logic [DATA_W*BEATS-1:0] hit_wdata_i,
  output logic                    hit_afull_o,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  output logic [DATA_W-1:0]       inct_rdata_o,
  output logic                    inct_rlast_o,
  output logic                    inct_rvalid_o,
  input  logic                    inct_rready_i,
  output logic [1:0]              err_o
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned FP_W  = $clog2(FLAG_DEPTH);
  localparam int unsigned FC_W  = FP_W + 1;
  localparam int unsigned HP_W  = $clog2(HIT_DEPTH);
  localparam int unsigned HC_W  = HP_W + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [FC_W-1:0]  F_FULL    = FC_W'(FLAG_DEPTH);
  localparam logic [FC_W-1:0]  F_AFULL   = FC_W'(FLAG_DEPTH - AFULL_MARGIN);
  localparam logic [HC_W-1:0]  H_FULL    = HC_W'(HIT_DEPTH);
  localparam logic [HC_W-1:0]  H_AFULL   = HC_W'(HIT_DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_MISS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flag FIFO (first-word fall-through)
  logic             f_mem [FLAG_DEPTH];
  logic [FP_W-1:0]  f_wp_q, f_rp_q;
  logic [FC_W-1:0]  f_cnt_q, f_cnt_d;
  logic             f_push, f_pop, f_full, f_nempty, f_head;

  // Hit-line FIFO (first-word fall-through), each entry viewed as BEATS beats
  logic [BEATS-1:0][DATA_W-1:0] h_mem [HIT_DEPTH];
  logic [BEATS-1:0][DATA_W-1:0] h_head;
  logic [HP_W-1:0]  h_wp_q, h_rp_q;
  logic [HC_W-1:0]  h_cnt_q, h_cnt_d;
  logic             h_push, h_pop, h_full, h_nempty;

  logic             len_err, ovf;

  assign f_full   = (f_cnt_q == F_FULL);
  assign f_nempty = (f_cnt_q != '0);
  assign f_head   = f_mem[f_rp_q];
  // A push into a full FIFO is accepted only when the same cycle frees a slot
  assign f_push   = flag_wren_i && (!f_full || f_pop);
  assign f_cnt_d  = f_cnt_q + FC_W'(f_push) - FC_W'(f_pop);

  assign h_full   = (h_cnt_q == H_FULL);
  assign h_nempty = (h_cnt_q != '0);
  assign h_head   = h_mem[h_rp_q];
  assign h_push   = hit_wren_i && (!h_full || h_pop);
  assign h_cnt_d  = h_cnt_q + HC_W'(h_push) - HC_W'(h_pop);

  assign ovf = (flag_wren_i && f_full && !f_pop) || (hit_wren_i && h_full && !h_pop);

  // Next-state, datapath mux and handshake-driven bookkeeping
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    f_pop         = 1'b0;
    h_pop         = 1'b0;
    len_err       = 1'b0;
    inct_rvalid_o = 1'b0;
    inct_rdata_o  = '0;
    inct_rlast_o  = 1'b0;
    mem_rready_o  = 1'b0;

    case (state_q)
      S_HIT: begin
        inct_rvalid_o = h_nempty;
        inct_rdata_o  = h_head[cnt_q];
        inct_rlast_o  = h_nempty && (cnt_q == LAST_BEAT);
      end
      S_MISS: begin
        inct_rvalid_o = mem_rvalid_i;
        inct_rdata_o  = mem_rdata_i;
        inct_rlast_o  = mem_rlast_i;
        mem_rready_o  = inct_rready_i;
      end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      if (f_nempty) begin
        f_pop   = 1'b1;
        cnt_d   = '0;
        state_d = f_head ? S_HIT : S_MISS;
      end
    end else if (inct_rvalid_o && inct_rready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      // Miss bursts must carry rlast exactly on the final beat of a line
      if ((state_q == S_MISS) && (inct_rlast_o != (cnt_q == LAST_BEAT)))
        len_err = 1'b1;
      if (inct_rlast_o) begin
        h_pop = (state_q == S_HIT);
        cnt_d = '0;
        if (f_nempty) begin
          f_pop   = 1'b1;
          state_d = f_head ? S_HIT : S_MISS;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  // Control state, pointers and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      f_wp_q       <= '0;
      f_rp_q       <= '0;
      f_cnt_q      <= '0;
      h_wp_q       <= '0;
      h_rp_q       <= '0;
      h_cnt_q      <= '0;
      flag_afull_o <= 1'b0;
      hit_afull_o  <= 1'b0;
      err_o        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (f_push) f_wp_q <= f_wp_q + FP_W'(1);
      if (f_pop)  f_rp_q <= f_rp_q + FP_W'(1);
      f_cnt_q <= f_cnt_d;
      if (h_push) h_wp_q <= h_wp_q + HP_W'(1);
      if (h_pop)  h_rp_q <= h_rp_q + HP_W'(1);
      h_cnt_q <= h_cnt_d;
      flag_afull_o <= (f_cnt_d >= F_AFULL);
      hit_afull_o  <= (h_cnt_d >= H_AFULL);
      err_o        <= err_o | {len_err, ovf};
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (f_push) f_mem[f_wp_q] <= flag_wdata_i;
    if (h_push) h_mem[h_wp_q] <= hit_wdata_i;
  end

endmodule

// File: tb/tb_cc_reorder_merge_unit.sv
// Scoreboard bench for cc_reorder_merge_unit: directed flag/line/burst sequences, beats checked
// in order by a monitor sampling INCT R handshakes on the falling edge.
module tb_cc_reorder_merge_unit;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned BEATS      = 8;
  localparam int unsigned FLAG_DEPTH = 4;
  localparam int unsigned HIT_DEPTH  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flag_wren_i, flag_wdata_i, flag_afull_o;
  logic                    hit_wren_i, hit_afull_o;
  logic [DATA_W*BEATS-1:0] hit_wdata_i;
  logic [DATA_W-1:0]       mem_rdata_i;
  logic                    mem_rlast_i, mem_rvalid_i, mem_rready_o;
  logic [DATA_W-1:0]       inct_rdata_o;
  logic                    inct_rlast_o, inct_rvalid_o, inct_rready_i;
  logic [1:0]              err_o;

  always #5 clk = ~clk;

  cc_reorder_merge_unit #(
    .DATA_W(DATA_W), .BEATS(BEATS), .FLAG_DEPTH(FLAG_DEPTH), .HIT_DEPTH(HIT_DEPTH), .AFULL_MARGIN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_wren_i(flag_wren_i), .flag_wdata_i(flag_wdata_i), .flag_afull_o(flag_afull_o),
    .hit_wren_i(hit_wren_i), .hit_wdata_i(hit_wdata_i), .hit_afull_o(hit_afull_o),
    .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rready_o(mem_rready_o),
    .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o),
    .inct_rready_i(inct_rready_i), .err_o(err_o)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    run_len = 0;
  int    max_run = 0;
  beat_t sb_q[$];
  beat_t mem_q[$];
  beat_t exp_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_line(input logic [15:0] base);
    beat_t b;
    for (int k = 0; k < int'(BEATS); k++) begin
      b.d = 64'(base) + 64'(k);
      b.l = (k == int'(BEATS) - 1);
      sb_q.push_back(b);
    end
  endtask

  // Miss burst of n beats, rlast on the last one; also expected on INCT in order
  task automatic add_miss(input logic [15:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = 64'(base) + 64'(k);
      b.l = (k == n - 1);
      mem_q.push_back(b);
      sb_q.push_back(b);
    end
  endtask

  task automatic push_flag(input logic v);
    @(posedge clk); #1;
    flag_wren_i  = 1'b1;
    flag_wdata_i = v;
    @(posedge clk); #1;
    flag_wren_i  = 1'b0;
  endtask

  task automatic push_line(input logic [15:0] base);
    logic [DATA_W*BEATS-1:0] line;
    for (int k = 0; k < int'(BEATS); k++) line[k*DATA_W +: DATA_W] = 64'(base) + 64'(k);
    @(posedge clk); #1;
    hit_wren_i  = 1'b1;
    hit_wdata_i = line;
    @(posedge clk); #1;
    hit_wren_i  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: every INCT handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && inct_rvalid_o && inct_rready_i) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%0h last=%0b with nothing expected",
                 inct_rdata_o, inct_rlast_o);
      end else begin
        exp_b = sb_q.pop_front();
        if (inct_rdata_o !== exp_b.d || inct_rlast_o !== exp_b.l) begin
          n_bad++;
          $display("FAIL beat: got data=%0h last=%0b expected data=%0h last=%0b",
                   inct_rdata_o, inct_rlast_o, exp_b.d, exp_b.l);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  // MC R driver: presents queued beats, advances on handshake
  initial begin
    logic hs;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_rlast_i  = 1'b0;
    forever begin
      if (mem_q.size() > 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_q[0].d;
        mem_rlast_i  = mem_q[0].l;
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_rlast_i  = 1'b0;
      end
      @(negedge clk);
      hs = mem_rvalid_i && mem_rready_o;
      @(posedge clk); #1;
      if (hs) void'(mem_q.pop_front());
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic              stall, hl;
    logic [DATA_W-1:0] hd;
    int                c;

    rst_n         = 1'b0;
    flag_wren_i   = 1'b0;
    flag_wdata_i  = 1'b0;
    hit_wren_i    = 1'b0;
    hit_wdata_i   = '0;
    inct_rready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 64'(inct_rvalid_o), 64'd0);
    chk("rst_rlast", 64'(inct_rlast_o), 64'd0);
    chk("rst_rdata", inct_rdata_o, 64'd0);
    chk("rst_mem_rready", 64'(mem_rready_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_flag_afull", 64'(flag_afull_o), 64'd0);
    chk("rst_hit_afull", 64'(hit_afull_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Flags 0,1,0,1: miss A, line L0, miss B, line L1, back to back
    push_line(16'h0000);
    push_line(16'h1000);
    chk("t1_hit_afull", 64'(hit_afull_o), 64'd1);
    add_miss(16'hA000, 8);
    exp_line(16'h0000);
    add_miss(16'hB000, 8);
    exp_line(16'h1000);
    max_run = 0;
    push_flag(1'b0);
    push_flag(1'b1);
    push_flag(1'b0);
    push_flag(1'b1);
    wait_drain("t1_drain", 200);
    chk("t1_zero_bubble_run", 64'(max_run), 64'd32);
    chk("t1_err", 64'(err_o), 64'd0);

    // Hit flag arrives before its line: rvalid must wait
    push_flag(1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("t2_wait_rvalid", 64'(inct_rvalid_o), 64'd0);
    end
    exp_line(16'h2000);
    push_line(16'h2000);
    wait_drain("t2_drain", 100);

    // Backpressure: rready toggles every cycle, held beats must stay stable
    inct_rready_i = 1'b0;
    exp_line(16'h3000);
    push_line(16'h3000);
    push_flag(1'b1);
    stall = 1'b0;
    hd    = '0;
    hl    = 1'b0;
    c     = 0;
    while (sb_q.size() != 0 && c < 80) begin
      @(negedge clk);
      if (stall) begin
        chk("t3_hold_data", inct_rdata_o, hd);
        chk("t3_hold_last", 64'(inct_rlast_o), 64'(hl));
      end
      stall = inct_rvalid_o && !inct_rready_i;
      hd    = inct_rdata_o;
      hl    = inct_rlast_o;
      @(posedge clk); #1;
      inct_rready_i = ~inct_rready_i;
      c++;
    end
    inct_rready_i = 1'b1;
    chk("t3_drain", 64'(sb_q.size()), 64'd0);

    // Short miss burst (rlast on beat 4), then a hit serviced normally
    add_miss(16'hC000, 5);
    exp_line(16'h4000);
    push_line(16'h4000);
    push_flag(1'b0);
    push_flag(1'b1);
    wait_drain("t4_drain", 100);
    chk("t4_err_len", 64'(err_o), 64'd2);

    // Park in HIT with no line so flags accumulate; overflow on the fifth
    push_flag(1'b1);
    push_flag(1'b0);
    push_flag(1'b0);
    chk("t5_afull_occ2", 64'(flag_afull_o), 64'd0);
    push_flag(1'b0);
    chk("t5_afull_occ3", 64'(flag_afull_o), 64'd1);
    push_flag(1'b0);
    chk("t5_err_full_ok", 64'(err_o), 64'd2);
    push_flag(1'b0);
    chk("t5_err_ovf", 64'(err_o), 64'd3);
    chk("t5_afull_full", 64'(flag_afull_o), 64'd1);

    // Release the parked hit, reset while beat 3 is presented
    for (int k = 0; k < 3; k++) begin
      exp_b.d = 64'h5000 + 64'(k);
      exp_b.l = 1'b0;
      sb_q.push_back(exp_b);
    end
    push_line(16'h5000);
    wait_drain("t6_three_beats", 50);
    chk("t6_at_beat3", inct_rdata_o, 64'h5003);
    rst_n         = 1'b0;
    inct_rready_i = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_rvalid", 64'(inct_rvalid_o), 64'd0);
    chk("t6_rst_rlast", 64'(inct_rlast_o), 64'd0);
    chk("t6_rst_rdata", inct_rdata_o, 64'd0);
    chk("t6_rst_err", 64'(err_o), 64'd0);
    chk("t6_rst_flag_afull", 64'(flag_afull_o), 64'd0);
    chk("t6_rst_hit_afull", 64'(hit_afull_o), 64'd0);
    rst_n         = 1'b1;
    inct_rready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_flags_discarded", 64'(mem_rready_o), 64'd0);
      chk("t6_idle_rvalid", 64'(inct_rvalid_o), 64'd0);
    end
    exp_line(16'h6000);
    push_line(16'h6000);
    push_flag(1'b1);
    wait_drain("t6_fresh_line", 100);
    chk("t6_final_err", 64'(err_o), 64'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
